score_disp_n: RTL and testbench
===============================

SCORE_DISP_N -- requirements
Module: score_disp_n

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of decimal digits displayed (2..8).
REQ-002 The block SHALL have parameter SCORE_W, default 10, giving the width of the binary score input.
REQ-003 The block SHALL have parameter SCAN_DIV, default 16, giving the digit-advance period of 2^SCAN_DIV clk cycles.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 clr  input  1  reset, asynchronous, active-high.
REQ-006 score  input  SCORE_W  unsigned binary score.
REQ-007 blank_lz  input  1  1 = blank leading zeros.
REQ-008 AN  output  DIGITS  digit anodes, active-low, one-hot-low while scanning.
REQ-009 SEGMENT  output  8  segments, active-low, bit7 = dp, bits6..0 = g..a.
REQ-010 SEGDT, SEGCLK, SEGEN, SEGCLR  output  1 each  serial segment-driver data, shift clock, latch/enable and clear (active-low).
REQ-011 ovf  output  1  score exceeds 10^DIGITS-1.
REQ-012 busy  output  1  conversion or serial frame in progress.

Function
REQ-013 The block SHALL register score every cycle and start a conversion when the registered score differs from the last converted value and the converter is idle.
REQ-014 The converter SHALL be a sequential shift-add-3 (double-dabble), one bit per cycle, MSB first, SCORE_W shift cycles, loading the display register on the following edge (start to load = SCORE_W+1 edges).
REQ-015 Score changes during a conversion SHALL NOT abort it; after it completes, a new conversion SHALL start on the latest registered score, so the final displayed value always equals the last stable score.
REQ-016 If score > 10^DIGITS-1 the display register SHALL load all nines and ovf SHALL be 1; otherwise ovf SHALL be 0; ovf SHALL update with the display register.
REQ-017 The display register SHALL update atomically; partial BCD results SHALL never reach AN, SEGMENT or SEGDT.
REQ-018 A SCAN_DIV-bit free-running counter SHALL advance the digit index on wrap, index 0..DIGITS-1, wrapping to 0.
REQ-019 AN[i] SHALL be 0 only while index = i; SEGMENT SHALL carry the active-low pattern of digit i, registered together with AN.
REQ-020 Decoding: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 (hex), dp always off.
REQ-021 With blank_lz=1, digits above the most significant nonzero digit SHALL output FF; digit 0 SHALL always be shown.
REQ-022 Serial FSM states IDLE, SHIFT_LO, SHIFT_HI, LATCH: a display-register load in IDLE SHALL start a frame on the next cycle.
REQ-023 A frame SHALL shift DIGITS*8 bits, digit DIGITS-1 first, bit7 first, same patterns (including blanking) as REQ-020/021.
REQ-024 Each bit SHALL take 2 cycles: SHIFT_LO (SEGCLK=0, SEGDT set), SHIFT_HI (SEGCLK=1, SEGDT held).
REQ-025 SEGEN SHALL be 0 during SHIFT states, pulse... SHALL be 0 in SHIFT states and 1 otherwise; LATCH SHALL last 1 cycle then return to IDLE.
REQ-026 A load during a frame SHALL set a pending flag; the frame completes, then exactly one more frame with the newest value follows.
REQ-027 busy SHALL be 1 whenever converter is not idle or serial FSM is not IDLE.

Reset
REQ-028 While clr=1: AN all ones, SEGMENT=FF, SEGDT=0, SEGCLK=0, SEGEN=0, SEGCLR=0, ovf=0, busy=0, display register and last-converted value 0, scan index 0, FSM IDLE.
REQ-029 After clr falls, SEGCLR SHALL be 1, and one conversion and one frame SHALL run unconditionally, even if score=0.
REQ-030 clr asserted mid-conversion or mid-frame SHALL force REQ-028 values immediately, with no partial frame completion.

Verification (DIGITS=4, SCORE_W=10, SCAN_DIV=2, 40 ns clk)
REQ-031 clr pulse, score=0, blank_lz=1 -> reset values; then only AN=1110 shows C0, other digits FF; one 32-bit frame FFFFFFC0.
REQ-032 score=1023, blank_lz=0 -> after 11 edges scan shows AN 1110/B0, 1101/A4, 1011/C0, 0111/F9; frame F9C0A4B0 MSB-first.
REQ-033 score stepped 1,2,3,4,5,6 at 100 ns intervals -> no torn digits; final display and last frame show 6; every frame ends with LATCH pulse.
REQ-034 Load mid-frame -> current frame 64 SHIFT cycles intact, SEGEN=0 throughout, then one frame with new value.
REQ-035 clr asserted at frame bit 13 -> same-cycle reset values; after release fresh conversion and full frame.
REQ-036 DIGITS=2, score=150 -> display 99, ovf=1; score=42 -> display 42, ovf=0.

Source files
------------

// File: rtl/score_disp_n.sv
// Binary score to multiplexed 7-segment display with a serial segment-driver frame.
// A sequential double-dabble converter feeds a display register that drives both the scan and the serial shifter.
module score_disp_n #(
  parameter int DIGITS   = 4,
  parameter int SCORE_W  = 10,
  parameter int SCAN_DIV = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [SCORE_W-1:0] score,
  input  logic               blank_lz,
  output logic [DIGITS-1:0]  AN,
  output logic [7:0]         SEGMENT,
  output logic               SEGDT,
  output logic               SEGCLK,
  output logic               SEGEN,
  output logic               SEGCLR,
  output logic               ovf,
  output logic               busy
);

  localparam int BCD_W   = DIGITS * 4;
  localparam int FRAME_W = DIGITS * 8;
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int CNT_W   = $clog2(SCORE_W + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT_LO = 2'd1;
  localparam logic [1:0] SHIFT_HI = 2'd2;
  localparam logic [1:0] LATCH    = 2'd3;

  function automatic longint unsigned max_value(input int d);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < d; i++) v = v * 10;
    return v - 1;
  endfunction

  localparam longint unsigned MAX_VAL = max_value(DIGITS);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  logic [SCORE_W-1:0] score_reg;
  logic [SCORE_W-1:0] last_val;
  logic               force_conv;
  logic               conv_active;
  logic [CNT_W-1:0]   conv_cnt;
  logic               conv_ovf;
  logic [SCORE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   disp;
  logic               load_pulse;

  logic [DIGITS-1:0]  lz;
  logic [7:0]         pat [DIGITS];
  logic [FRAME_W-1:0] frame_word;

  logic [SCAN_DIV-1:0] scan_cnt;
  logic [IDX_W-1:0]    idx;

  logic [1:0]         state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] frame_sr;
  logic               pending;

  // Plain sampling register, left out of reset so the first conversion after clr sees the live score.
  always_ff @(posedge clk) begin
    score_reg <= score;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[gi*4 +: 4] = (bcd_sr[gi*4 +: 4] >= 4'd5) ? bcd_sr[gi*4 +: 4] + 4'd3
                                                               : bcd_sr[gi*4 +: 4];
      if (gi == 0) begin : g_low
        assign pat[gi] = seg7(disp[3:0]);
      end else begin : g_high
        assign pat[gi] = (blank_lz && lz[gi]) ? 8'hFF : seg7(disp[gi*4 +: 4]);
      end
      assign frame_word[gi*8 +: 8] = pat[gi];
    end
  endgenerate

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp[i*4 +: 4] == 4'd0);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_val    <= '0;
      force_conv  <= 1'b1;
      conv_active <= 1'b0;
      conv_cnt    <= '0;
      conv_ovf    <= 1'b0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      disp        <= '0;
      ovf         <= 1'b0;
      load_pulse  <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      if (!conv_active) begin
        if (force_conv || (score_reg != last_val)) begin
          conv_active <= 1'b1;
          force_conv  <= 1'b0;
          last_val    <= score_reg;
          bin_sr      <= score_reg;
          bcd_sr      <= '0;
          conv_cnt    <= '0;
          conv_ovf    <= 64'(score_reg) > MAX_VAL;
        end
      end else if (conv_cnt != CNT_W'(SCORE_W)) begin
        bcd_sr   <= (bcd_adj << 1) | BCD_W'(bin_sr[SCORE_W-1]);
        bin_sr   <= bin_sr << 1;
        conv_cnt <= conv_cnt + CNT_W'(1);
      end else begin
        // Whole result lands in one edge so no half-converted digits are ever displayed.
        conv_active <= 1'b0;
        disp        <= conv_ovf ? {DIGITS{4'h9}} : bcd_sr;
        ovf         <= conv_ovf;
        load_pulse  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scan_cnt <= '0;
      idx      <= '0;
      AN       <= '1;
      SEGMENT  <= 8'hFF;
    end else begin
      scan_cnt <= scan_cnt + SCAN_DIV'(1);
      if (&scan_cnt) begin
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
      AN      <= ~(DIGITS'(1) << idx);
      SEGMENT <= pat[idx];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      frame_sr <= '0;
      pending  <= 1'b0;
      SEGDT    <= 1'b0;
      SEGCLR   <= 1'b0;
    end else begin
      SEGCLR <= 1'b1;
      if (load_pulse) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (load_pulse || pending) begin
            state    <= SHIFT_LO;
            pending  <= 1'b0;
            frame_sr <= frame_word;
            SEGDT    <= frame_word[FRAME_W-1];
            bit_cnt  <= '0;
          end
        end
        SHIFT_LO: state <= SHIFT_HI;
        SHIFT_HI: begin
          if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
            state <= LATCH;
          end else begin
            state    <= SHIFT_LO;
            frame_sr <= frame_sr << 1;
            SEGDT    <= frame_sr[FRAME_W-2];
            bit_cnt  <= bit_cnt + BIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SEGCLR doubles as the out-of-reset flag so SEGEN stays low while clr is held.
  assign SEGCLK = (state == SHIFT_HI);
  assign SEGEN  = SEGCLR && (state != SHIFT_LO) && (state != SHIFT_HI);
  // A completed load waiting one cycle for the frame start still counts as work in progress.
  assign busy   = conv_active || load_pulse || (state != IDLE);

endmodule

// File: tb/tb_score_disp_n.sv
// Directed bench for score_disp_n: a 4-digit instance plus a 2-digit instance for overflow.
module tb_score_disp_n;

  logic       clk = 1'b0;
  logic       clr;
  logic [9:0] score;
  logic [9:0] score2;
  logic       blank_lz;
  bit         sel2;

  logic [3:0] an1;
  logic [7:0] seg1;
  logic       segdt1, segclk1, segen1, segclr1, ovf1, busy1;
  logic [1:0] an2;
  logic [7:0] seg2;
  logic       segdt2, segclk2, segen2, segclr2, ovf2, busy2;

  logic [3:0] m_an;
  logic [7:0] m_seg;
  logic       m_segdt, m_segclk, m_segen, m_busy;

  int tests = 0;
  int fails = 0;

  always #20 clk = ~clk;

  score_disp_n #(.DIGITS(4), .SCORE_W(10), .SCAN_DIV(2)) u_dut (
    .clk(clk), .clr(clr), .score(score), .blank_lz(blank_lz),
    .AN(an1), .SEGMENT(seg1), .SEGDT(segdt1), .SEGCLK(segclk1),
    .SEGEN(segen1), .SEGCLR(segclr1), .ovf(ovf1), .busy(busy1)
  );

  score_disp_n #(.DIGITS(2), .SCORE_W(10), .SCAN_DIV(2)) u_dut2 (
    .clk(clk), .clr(clr), .score(score2), .blank_lz(blank_lz),
    .AN(an2), .SEGMENT(seg2), .SEGDT(segdt2), .SEGCLK(segclk2),
    .SEGEN(segen2), .SEGCLR(segclr2), .ovf(ovf2), .busy(busy2)
  );

  assign m_an     = sel2 ? {2'b11, an2} : an1;
  assign m_seg    = sel2 ? seg2 : seg1;
  assign m_segdt  = sel2 ? segdt2 : segdt1;
  assign m_segclk = sel2 ? segclk2 : segclk1;
  assign m_segen  = sel2 ? segen2 : segen1;
  assign m_busy   = sel2 ? busy2 : busy1;

  task automatic wait_idle(input string name);
    int quiet = 0;
    int cyc = 0;
    while (quiet < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (m_busy === 1'b0) quiet++;
      else quiet = 0;
    end
    tests++;
    if (quiet < 4) begin
      fails++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, m_busy, cyc);
    end
  endtask

  // Call at a negedge with SEGEN high; returns at the negedge where SEGEN is high again.
  task automatic capture_frame(input int max_wait, output logic [63:0] data, output int nbits,
                               output int shifts, output int wait_cyc, output bit got,
                               output bit latched);
    data = '0; nbits = 0; shifts = 0; wait_cyc = 0; got = 1'b0; latched = 1'b0;
    while (wait_cyc < max_wait) begin
      @(negedge clk);
      wait_cyc++;
      if (m_segen === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      while (m_segen === 1'b0 && shifts < 300) begin
        shifts++;
        if (m_segclk === 1'b1) begin
          data = {data[62:0], m_segdt};
          nbits++;
        end
        @(negedge clk);
      end
      latched = (m_segen === 1'b1) && (m_segclk === 1'b0);
      $display("[TB] frame %h bits %0d shift_cycles %0d start_after %0d", data, nbits, shifts, wait_cyc);
    end
  endtask

  task automatic check_scan(input string name, input logic [31:0] expw, input int ndig);
    int seen = 0;
    int di;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      case (m_an)
        4'b1110: di = 0;
        4'b1101: di = 1;
        4'b1011: di = 2;
        4'b0111: di = 3;
        default: di = -1;
      endcase
      tests++;
      if (di < 0 || di >= ndig) begin
        fails++;
        $display("FAIL %s_an: AN=%b, required one-hot-low within %0d digits", name, m_an, ndig);
      end else if (m_seg !== expw[di*8 +: 8]) begin
        fails++;
        $display("FAIL %s_seg: digit %0d SEGMENT=%h, required %h", name, di, m_seg, expw[di*8 +: 8]);
      end else begin
        seen = seen | (1 << di);
      end
    end
    tests++;
    if (seen != (1 << ndig) - 1) begin
      fails++;
      $display("FAIL %s_coverage: digits seen mask %b, required %b", name, seen, (1 << ndig) - 1);
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [17:0] act;
    act = {an1, seg1, segdt1, segclk1, segen1, segclr1, ovf1, busy1};
    tests++;
    if (act !== {4'hF, 8'hFF, 6'b000000}) begin
      fails++;
      $display("FAIL %s: {AN,SEGMENT,SEGDT,SEGCLK,SEGEN,SEGCLR,ovf,busy}=%h, required %h",
               name, act, {4'hF, 8'hFF, 6'b000000});
    end
  endtask

  task automatic check_frame(input string name, input logic [63:0] data, input logic [63:0] expd,
                             input int nbits, input int shifts, input bit latched, input int nb_req);
    tests++;
    if (data !== expd) begin
      fails++;
      $display("FAIL %s_data: frame %h, required %h", name, data, expd);
    end
    tests++;
    if (nbits != nb_req || shifts != 2 * nb_req || !latched) begin
      fails++;
      $display("FAIL %s_shape: bits %0d shift_cycles %0d latch %0d, required %0d %0d 1",
               name, nbits, shifts, latched, nb_req, 2 * nb_req);
    end
  endtask

  task automatic test_reset();
    logic [63:0] d; int nb, sh, wc; bit got, lat;
    clr = 1'b1; score = '0; score2 = '0; blank_lz = 1'b1; sel2 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_hold");
    clr = 1'b0;
    @(negedge clk);
    tests++;
    if (segclr1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_segclr: SEGCLR=%b, required 1", segclr1);
    end
    capture_frame(60, d, nb, sh, wc, got, lat);
    check_frame("reset_frame", d, 64'hFFFFFFC0, nb, sh, lat, 32);
    wait_idle("reset");
    check_scan("reset_scan", 32'hFFFFFFC0, 4);
  endtask

  task automatic test_convert();
    logic [63:0] d; int nb, sh, wc; bit got, lat;
    blank_lz = 1'b0;
    score = 10'd1023;
    capture_frame(60, d, nb, sh, wc, got, lat);
    tests++;
    if (wc != 14) begin
      fails++;
      $display("FAIL convert_latency: frame started after %0d cycles, required 14", wc);
    end
    check_frame("convert_frame", d, 64'hF9C0A4B0, nb, sh, lat, 32);
    wait_idle("convert");
    check_scan("convert_scan", 32'hF9C0A4B0, 4);
    tests++;
    if (ovf1 !== 1'b0) begin
      fails++;
      $display("FAIL convert_ovf: ovf=%b, required 0", ovf1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d; logic [63:0] last_d; int nb, sh, wc; bit got, lat;
    int nfr = 0;
    bit done = 1'b0;
    last_d = '0;
    blank_lz = 1'b1;
    fork
      begin
        #10 score = 10'd1;
        repeat (5) #100 score = score + 10'd1;
      end
      begin
        while (!done && nfr < 8) begin
          capture_frame(80, d, nb, sh, wc, got, lat);
          if (!got) done = 1'b1;
          else begin
            nfr++;
            last_d = d;
            tests++;
            case (d)
              64'hFFFFFFF9, 64'hFFFFFFA4, 64'hFFFFFFB0,
              64'hFFFFFF99, 64'hFFFFFF92, 64'hFFFFFF82: ;
              default: begin
                fails++;
                $display("FAIL b2b_torn: frame %h, required one of the values 1..6", d);
              end
            endcase
            tests++;
            if (nb != 32 || sh != 64 || !lat) begin
              fails++;
              $display("FAIL b2b_shape: bits %0d shift_cycles %0d latch %0d, required 32 64 1", nb, sh, lat);
            end
          end
        end
      end
    join
    tests++;
    if (nfr == 0 || last_d !== 64'hFFFFFF82) begin
      fails++;
      $display("FAIL b2b_last: %0d frames, last %h, required >=1 frames ending FFFFFF82", nfr, last_d);
    end
    wait_idle("b2b");
    check_scan("b2b_scan", 32'hFFFFFF82, 4);
  endtask

  task automatic test_mid_frame_load();
    logic [63:0] d1, d2, d3; int nb1, nb2, nb3, sh1, sh2, sh3, wc; bit g1, g2, g3, l1, l2, l3;
    wait_idle("midload_pre");
    blank_lz = 1'b0;
    score = 10'd1023;
    fork
      begin
        capture_frame(60, d1, nb1, sh1, wc, g1, l1);
        capture_frame(150, d2, nb2, sh2, wc, g2, l2);
        capture_frame(100, d3, nb3, sh3, wc, g3, l3);
      end
      begin
        int c = 0;
        while (segen1 !== 1'b0 && c < 100) begin
          @(negedge clk);
          c++;
        end
        repeat (10) @(negedge clk);
        score = 10'd42;
      end
    join
    check_frame("midload_first", d1, 64'hF9C0A4B0, nb1, sh1, l1, 32);
    check_frame("midload_second", d2, 64'hC0C099A4, nb2, sh2, l2, 32);
    tests++;
    if (g3) begin
      fails++;
      $display("FAIL midload_extra: third frame %h seen, required none", d3);
    end
  endtask

  task automatic test_clr_mid_frame();
    logic [63:0] d; int nb, sh, wc; bit got, lat;
    int c = 0;
    int nbit = 0;
    wait_idle("clrmid_pre");
    blank_lz = 1'b1;
    score = 10'd500;
    while (segen1 !== 1'b0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    while (nbit < 13 && c < 300) begin
      if (segclk1 === 1'b1) nbit++;
      @(negedge clk);
      c++;
    end
    tests++;
    if (nbit != 13 || segen1 !== 1'b0) begin
      fails++;
      $display("FAIL clrmid_reach: bits %0d SEGEN %b, required 13 0", nbit, segen1);
    end
    #5 clr = 1'b1;
    #1 check_reset_vals("clrmid_immediate");
    @(negedge clk);
    check_reset_vals("clrmid_held");
    clr = 1'b0;
    @(negedge clk);
    capture_frame(60, d, nb, sh, wc, got, lat);
    check_frame("clrmid_frame", d, 64'hFF92C0C0, nb, sh, lat, 32);
  endtask

  task automatic test_overflow();
    logic [63:0] d; int nb, sh, wc; bit got, lat;
    sel2 = 1'b1;
    wait_idle("ovf_pre");
    score2 = 10'd150;
    capture_frame(60, d, nb, sh, wc, got, lat);
    check_frame("ovf_frame", d, 64'h9090, nb, sh, lat, 16);
    tests++;
    if (ovf2 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flag: ovf=%b, required 1", ovf2);
    end
    wait_idle("ovf");
    check_scan("ovf_scan", 32'hFFFF9090, 2);
    score2 = 10'd42;
    capture_frame(60, d, nb, sh, wc, got, lat);
    check_frame("ovf_clear_frame", d, 64'h99A4, nb, sh, lat, 16);
    tests++;
    if (ovf2 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b, required 0", ovf2);
    end
    sel2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_back_to_back();
    test_mid_frame_load();
    test_clr_mid_frame();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
